// File: rtl/div_ctrl.sv
// div_ctrl: sequences one DIV/DIVU through an external iterative divider, stalls IF/ID/EX, writes HI/LO.
// Latency: set by dv_ready_i (36 cycles nominal); optional DIV_ZERO_FLAG_EN adds dbz_o and a 1-cycle zero-divisor path.
// Backpressure: stall_o holds the pipe while a request is being accepted, is in flight, or waits out a cancel.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    output logic        dv_start_o,
    output logic        dv_signed_o,
    output logic        dv_annul_o,
    output logic [31:0] dv_op1_o,
    output logic [31:0] dv_op2_o,
    input  logic [63:0] dv_result_i,
    input  logic        dv_ready_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic        dbz_o,
`endif
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_DONE   = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    localparam logic [1:0] CANCEL_LAST = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] op1_q, op2_q;
    logic        sgn_q;
    logic [31:0] hi_q, lo_q;
    logic        accept;
    logic        capture;

`ifdef DIV_ZERO_FLAG_EN
    logic        dbz_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (div_req_i && !flush_i) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    state_d = (op_b_i == 32'd0) ? S_DONE : S_WAIT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WAIT: begin
                // A squash wins even when the result lands in the same cycle.
                if (flush_i) begin
                    state_d = S_CANCEL;
                    cnt_d   = 2'd0;
                end else if (dv_ready_i) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_CANCEL: begin
                if (cnt_q == CANCEL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op1_q <= op_a_i;
                op2_q <= op_b_i;
                sgn_q <= div_signed_i;
            end
            if (capture) begin
                hi_q <= dv_result_i[63:32];
                lo_q <= dv_result_i[31:0];
            end
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else if (accept) begin
            dbz_q <= (op_b_i == 32'd0);
        end
    end

    assign dbz_o     = !rst && (state_q == S_DONE) && dbz_q;
    assign hilo_we_o = !rst && (state_q == S_DONE) && !dbz_q;
`else
    assign hilo_we_o = !rst && (state_q == S_DONE);
`endif

    // Control outputs are forced low while rst is high; the divider is reset alongside, so no annul.
    assign dv_start_o  = !rst && (state_q == S_WAIT);
    assign dv_annul_o  = !rst && (state_q == S_WAIT) && flush_i;
    assign dv_signed_o = sgn_q;
    assign dv_op1_o    = op1_q;
    assign dv_op2_o    = op2_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign busy_o      = !rst && (state_q != S_IDLE);
    assign stall_o     = !rst && (((state_q == S_IDLE) && div_req_i && !flush_i) ||
                                  (state_q == S_WAIT) ||
                                  ((state_q == S_CANCEL) && div_req_i && !flush_i));

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: emulated divider with programmable latency, transaction-level model, directed + random ops.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_req = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        flush = 1'b0;
    logic        dv_start_o, dv_signed_o, dv_annul_o;
    logic [31:0] dv_op1_o, dv_op2_o;
    logic [63:0] dv_result = 64'd0;
    logic        dv_ready = 1'b0;
    logic        stall_o, hilo_we_o, busy_o;
    logic [31:0] hi_o, lo_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        dbz_o;
`endif

    int errors = 0;
    int checks = 0;
    int dv_lat = 34;
    int dv_cnt = 0;
    int we_cnt = 0, annul_cnt = 0, start_cnt = 0, dbz_cnt = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .rst(rst),
        .div_req_i(div_req), .div_signed_i(div_signed),
        .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
        .dv_start_o(dv_start_o), .dv_signed_o(dv_signed_o), .dv_annul_o(dv_annul_o),
        .dv_op1_o(dv_op1_o), .dv_op2_o(dv_op2_o),
        .dv_result_i(dv_result), .dv_ready_i(dv_ready),
        .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
`ifdef DIV_ZERO_FLAG_EN
        .dbz_o(dbz_o),
`endif
        .busy_o(busy_o)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural MIPS DIV/DIVU: {remainder, quotient}; truncating division, zero divisor yields 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider emulation: result ready dv_lat+1 cycles into a start, registered.
    always @(posedge clk) begin
        if (rst || dv_annul_o) begin
            dv_cnt   <= 0;
            dv_ready <= 1'b0;
        end else if (dv_start_o && !dv_ready) begin
            if (dv_cnt == dv_lat - 1) begin
                dv_ready  <= 1'b1;
                dv_result <= ref_div(dv_op1_o, dv_op2_o, dv_signed_o);
            end
            dv_cnt <= dv_cnt + 1;
        end else begin
            dv_cnt   <= 0;
            dv_ready <= 1'b0;
        end
    end

    // Transaction-level model: is a divide in flight, is this the write-back cycle, cancel cycles left.
    bit          m_wait = 0, m_done = 0, m_dbz = 0;
    int          m_cancel = 0;
    logic [31:0] m_op1 = 0, m_op2 = 0, m_hi = 0, m_lo = 0;
    logic        m_sg = 0;

    initial begin
        bit m_idle, acc;
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_idle = !m_wait && !m_done && (m_cancel == 0);
            acc    = m_idle && div_req && !flush;
            chk1("dv_start", dv_start_o, !rst && m_wait);
            chk1("dv_annul", dv_annul_o, !rst && m_wait && flush);
            chk1("stall", stall_o, !rst && (acc || m_wait || (m_cancel > 0 && div_req && !flush)));
            chk1("hilo_we", hilo_we_o, !rst && m_done && !m_dbz);
            chk1("busy", busy_o, !rst && !m_idle);
            chk32("hi", hi_o, m_hi);
            chk32("lo", lo_o, m_lo);
            chk32("dv_op1", dv_op1_o, m_op1);
            chk32("dv_op2", dv_op2_o, m_op2);
            chk1("dv_signed", dv_signed_o, m_sg);
`ifdef DIV_ZERO_FLAG_EN
            chk1("dbz", dbz_o, !rst && m_done && m_dbz);
            if (dbz_o) dbz_cnt++;
`endif
            if (hilo_we_o) we_cnt++;
            if (dv_annul_o) annul_cnt++;
            if (dv_start_o) start_cnt++;

            if (rst) begin
                m_wait = 0; m_done = 0; m_dbz = 0; m_cancel = 0;
                m_op1 = 0; m_op2 = 0; m_sg = 0; m_hi = 0; m_lo = 0;
            end else if (m_wait) begin
                if (flush) begin
                    m_wait = 0; m_cancel = 3;
                end else if (dv_ready) begin
                    m_hi = dv_result[63:32]; m_lo = dv_result[31:0];
                    m_wait = 0; m_done = 1;
                end
            end else if (m_done) begin
                m_done = 0; m_dbz = 0;
            end else if (m_cancel > 0) begin
                m_cancel--;
            end else if (acc) begin
                m_op1 = op_a; m_op2 = op_b; m_sg = div_signed;
`ifdef DIV_ZERO_FLAG_EN
                if (op_b == 32'd0) begin m_done = 1; m_dbz = 1; end
                else m_wait = 1;
`else
                m_wait = 1;
`endif
            end
        end
    end

    // Called at posedge+1; holds the request while stalled, returns at posedge+1 after the op leaves EX.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input int fl_at, input int rs_at, output int stalls);
        int n;
        n = 0;
        stalls = 0;
        div_req = 1'b1; op_a = a; op_b = b; div_signed = sg;
        forever begin
            flush = (n == fl_at);
            rst   = (n == rs_at);
            @(negedge clk);
            if (stall_o) stalls++;
            if (flush || rst || !stall_o) break;
            if (n >= 400) begin
                checks++; errors++;
                $display("FAIL op_timeout: still stalled after %0d cycles, want completion", n);
                break;
            end
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        div_req = 1'b0; flush = 1'b0; rst = 1'b0;
        op_a = $urandom; op_b = $urandom; div_signed = 1'(($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int st, we0, an0, sc0, bc, d0;
        logic [31:0] a, b;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk1("reset_busy", busy_o, 1'b0);
        chk1("reset_stall", stall_o, 1'b0);
        chk32("reset_hi", hi_o, 32'd0);
        chk32("reset_lo", lo_o, 32'd0);
        @(posedge clk); #1;

        dv_lat = 34; we0 = we_cnt;
        do_div(32'd100, 32'd7, 1'b0, -1, -1, st);
        chk32("divu100_7_stall", st, 32'd36);
        chk32("divu100_7_lo", lo_o, 32'd14);
        chk32("divu100_7_hi", hi_o, 32'd2);
        chk32("divu100_7_we", we_cnt - we0, 32'd1);

        dv_lat = 6;
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, -1, -1, st);
        chk32("div_m7_2_lo", lo_o, 32'hFFFFFFFD);
        chk32("div_m7_2_hi", hi_o, 32'hFFFFFFFF);

        dv_lat = 34; we0 = we_cnt; an0 = annul_cnt;
        do_div(32'd50, 32'd5, 1'b0, 10, -1, st);
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy_o) bc++;
            @(posedge clk); #1;
        end
        chk32("flush_cancel_cycles", bc, 32'd3);
        chk32("flush_annul", annul_cnt - an0, 32'd1);
        chk32("flush_no_we", we_cnt - we0, 32'd0);
        dv_lat = 4;
        do_div(32'd9, 32'd3, 1'b0, -1, -1, st);
        chk32("divu9_3_lo", lo_o, 32'd3);
        chk32("divu9_3_hi", hi_o, 32'd0);

        dv_lat = 5; we0 = we_cnt; an0 = annul_cnt;
        do_div(32'd77, 32'd5, 1'b0, 6, -1, st);
        idle(5);
        chk32("flush_ready_no_we", we_cnt - we0, 32'd0);
        chk32("flush_ready_annul", annul_cnt - an0, 32'd1);
        chk32("flush_ready_lo_held", lo_o, 32'd3);

        dv_lat = 3; we0 = we_cnt;
        do_div(32'd7, 32'd2, 1'b0, -1, -1, st);
        chk32("b2b_first_lo", lo_o, 32'd3);
        chk32("b2b_first_hi", hi_o, 32'd1);
        do_div(32'd8, 32'd3, 1'b0, -1, -1, st);
        chk32("b2b_second_lo", lo_o, 32'd2);
        chk32("b2b_second_hi", hi_o, 32'd2);
        chk32("b2b_we", we_cnt - we0, 32'd2);

        we0 = we_cnt; sc0 = start_cnt;
`ifdef DIV_ZERO_FLAG_EN
        d0 = dbz_cnt;
`else
        d0 = 0;
`endif
        do_div(32'd5, 32'd0, 1'b0, -1, -1, st);
        idle(1);
`ifdef DIV_ZERO_FLAG_EN
        chk32("dbz_stall", st, 32'd1);
        chk32("dbz_pulse", dbz_cnt - d0, 32'd1);
        chk32("dbz_no_we", we_cnt - we0, 32'd0);
        chk32("dbz_no_start", start_cnt - sc0, 32'd0);
        chk32("dbz_lo_held", lo_o, 32'd2);
`else
        chk32("div0_we", we_cnt - we0 + d0, 32'd1);
        chk32("div0_lo", lo_o, 32'd0);
        chk32("div0_hi", hi_o, 32'd0);
        chk1("div0_started", start_cnt > sc0, 1'b1);
`endif

        dv_lat = 34;
        do_div(32'd100, 32'd7, 1'b0, -1, 20, st);
        @(negedge clk);
        chk1("rst_mid_busy", busy_o, 1'b0);
        chk1("rst_mid_start", dv_start_o, 1'b0);
        chk32("rst_mid_hi", hi_o, 32'd0);
        chk32("rst_mid_lo", lo_o, 32'd0);
        @(posedge clk); #1;
        dv_lat = 8;
        do_div(32'd12, 32'd4, 1'b0, -1, -1, st);
        chk32("divu12_4_lo", lo_o, 32'd3);
        chk32("divu12_4_hi", hi_o, 32'd0);

        for (int k = 0; k < 80; k++) begin
            int r, fl, rs;
            a = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r < 4) b = $urandom_range(1, 15);
            else if (r == 4) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else b = $urandom;
            dv_lat = $urandom_range(1, 34);
            fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, dv_lat + 2) : -1;
            rs = (fl < 0 && $urandom_range(0, 19) == 0) ? $urandom_range(1, dv_lat) : -1;
            do_div(a, b, 1'(($urandom)), fl, rs, st);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                flush = ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
                flush = 1'b0;
            end
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 div_req_i  in  1  EX stage holds a DIV/DIVU instruction; held high while stalled.
REQ-004 div_signed_i  in  1  1 = DIV, 0 = DIVU.
REQ-005 op_a_i / op_b_i  in  32 each  dividend / divisor from EX.
REQ-006 flush_i  in  1  EX instruction squashed this cycle.
REQ-007 dv_start_o / dv_signed_o / dv_annul_o  out  1 each  request, signedness and cancel to the divider.
REQ-008 dv_op1_o / dv_op2_o  out  32 each  latched operands to the divider.
REQ-009 dv_result_i  in  64  divider result: [63:32] remainder, [31:0] quotient.
REQ-010 dv_ready_i  in  1  divider result valid; registered by the divider.
REQ-011 stall_o  out  1  freeze IF/ID/EX (combinational).
REQ-012 hilo_we_o  out  1  one-cycle HI/LO write strobe.
REQ-013 hi_o / lo_o  out  32 each  remainder / quotient, valid while hilo_we_o=1.
REQ-014 busy_o  out  1  state != IDLE.

Function
REQ-015 States: IDLE, WAIT, DONE, CANCEL; encoded in 2 bits.
REQ-016 IDLE: div_req_i=1 and flush_i=0 -> latch op_a_i, op_b_i, div_signed_i; go to WAIT; otherwise stay.
REQ-017 dv_start_o = (state==WAIT); dv_op1_o, dv_op2_o, dv_signed_o are driven from the latches and stay stable throughout WAIT.
REQ-018 WAIT: dv_ready_i=1 and flush_i=0 -> capture hi=dv_result_i[63:32], lo=dv_result_i[31:0]; go to DONE.
REQ-019 DONE (exactly 1 cycle): hilo_we_o=1, dv_start_o=0, stall_o=0; go to IDLE; no new request accepted in DONE.
REQ-020 stall_o = (IDLE & div_req_i & ~flush_i) | WAIT | (CANCEL & div_req_i & ~flush_i).
REQ-021 WAIT with flush_i=1, including when dv_ready_i=1: dv_annul_o=1 that cycle; no capture; go to CANCEL; flush has priority over ready.
REQ-022 CANCEL: dv_start_o=0 for exactly 3 cycles, counted by a 2-bit counter; then go to IDLE. Requests arriving in CANCEL stall and are accepted only from IDLE.
REQ-023 Nominal latency from acceptance in IDLE to hilo_we_o is 36 cycles for a 32-step divider; the block relies only on dv_ready_i and never counts steps.
REQ-024 flush_i in IDLE/DONE/CANCEL: no state effect other than suppressing acceptance in IDLE.
REQ-025 hi_o/lo_o hold their last captured value outside DONE.

Reset
REQ-026 rst=1 at any cycle, including mid-WAIT: state=IDLE, CANCEL counter=0, operand latches=0, hi/lo=0; dv_start_o, dv_annul_o, hilo_we_o, stall_o, busy_o=0. The divider shares rst, so no annul is issued.

Configuration
REQ-027 Macro DIV_ZERO_FLAG_EN defined: extra output dbz_o (1 bit). An IDLE acceptance with op_b_i=0 goes straight to DONE without asserting dv_start_o, giving a 1-cycle stall. In that DONE cycle dbz_o=1 and hilo_we_o=0, so HI/LO are unchanged.
REQ-028 Macro undefined: dbz_o does not exist. A zero divisor is issued to the divider like any other request, and the divider's zero result is written.

Verification
REQ-029 DIVU 100/7 -> stall ~36 cycles; hilo_we_o pulses once; lo_o=14, hi_o=2.
REQ-030 DIV 0xFFFFFFF9/2 (-7/2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-031 DIVU 50/5 with flush_i at WAIT cycle 10 -> dv_annul_o=1 for one cycle, no hilo_we_o, 3 CANCEL cycles with dv_start_o=0. A following DIVU 9/3 returns lo_o=3, hi_o=0 with no stale result.
REQ-032 Back-to-back DIVU 7/2 then DIVU 8/3 -> two hilo_we_o pulses, values (1,3) then (2,2). Second dv_start_o rises only after the one-cycle DONE and IDLE gap.
REQ-033 DIVU 5/0: with DIV_ZERO_FLAG_EN, dbz_o=1 after a 1-cycle stall, no hilo_we_o, dv_start_o never 1. Without it, hilo_we_o with hi_o=0, lo_o=0.
REQ-034 rst at WAIT cycle 20 -> all outputs 0 on the next edge; a subsequent DIVU 12/4 returns lo_o=3, hi_o=0.
